// File: rtl/apb_master_arb.sv
// apb_master_arb
//   Shares one APB slave port between two local requesters. A round-robin
//   arbiter picks a winner in IDLE, latches its command onto the APB bus,
//   runs SETUP/ACCESS (honouring p_ready wait states) and returns read data
//   and error status with a one-cycle done pulse. A watchdog ends an ACCESS
//   phase that waits too long on p_ready and reports it as an error.
//
// Ports
//   p_clk, p_reset_n          clock, synchronous active-low reset
//   req{0,1}_valid/write/addr/wdata   requester commands
//   gnt[1:0]                  one-hot accept pulse (SETUP cycle)
//   done[1:0]                 one-hot completion pulse (IDLE cycle after ACCESS)
//   rsp_rdata, rsp_err        response, valid with done, held until next done
//   busy                      high in SETUP and ACCESS
//   p_sel, p_enable, p_write, p_addr, p_w_data   APB master outputs
//   p_ready, p_slv_err, p_r_data                 APB slave responses
//
// state  | meaning
// IDLE   | bus idle; arbitrate and latch the winner's command
// SETUP  | APB setup phase (p_sel=1, p_enable=0); clear watchdog
// ACCESS | APB access phase; wait for p_ready or watchdog expiry

module apb_master_arb #(
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              p_clk,
   input  logic              p_reset_n,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              p_sel,
   output logic              p_enable,
   output logic              p_write,
   output logic [ADDR_W-1:0] p_addr,
   output logic [DATA_W-1:0] p_w_data,
   input  logic              p_ready,
   input  logic              p_slv_err,
   input  logic [DATA_W-1:0] p_r_data
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   // Count value seen during the last permitted ACCESS cycle.
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   state_t          state;
   logic            last_grant;
   logic            win;
   logic [TW-1:0]   tcnt;

   logic any_req;
   logic pick1;
   logic timed_out;

   assign any_req   = req0_valid | req1_valid;
   // Requester 1 wins when alone, or when both ask and requester 0 won last.
   assign pick1     = req1_valid & (~req0_valid | ~last_grant);
   assign timed_out = (tcnt == TCNT_LAST);
   assign busy      = (state != IDLE);

   always_ff @(posedge p_clk) begin
      if (!p_reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         win        <= 1'b0;
         tcnt       <= '0;
         gnt        <= '0;
         done       <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         p_sel      <= 1'b0;
         p_enable   <= 1'b0;
         p_write    <= 1'b0;
         p_addr     <= '0;
         p_w_data   <= '0;
      end else begin
         gnt  <= '0;
         done <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state      <= SETUP;
                  win        <= pick1;
                  last_grant <= pick1;
                  gnt        <= pick1 ? 2'b10 : 2'b01;
                  p_sel      <= 1'b1;
                  p_enable   <= 1'b0;
                  p_write    <= pick1 ? req1_write : req0_write;
                  p_addr     <= pick1 ? req1_addr  : req0_addr;
                  p_w_data   <= pick1 ? req1_wdata : req0_wdata;
               end
            end
            SETUP: begin
               state    <= ACCESS;
               p_enable <= 1'b1;
               tcnt     <= '0;
            end
            ACCESS: begin
               if (p_ready || timed_out) begin
                  state    <= IDLE;
                  p_sel    <= 1'b0;
                  p_enable <= 1'b0;
                  done     <= win ? 2'b10 : 2'b01;
                  // A genuine p_ready takes priority over an expiring watchdog.
                  if (p_ready) begin
                     rsp_err   <= p_slv_err;
                     rsp_rdata <= p_write ? '0 : p_r_data;
                  end else begin
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arb.sv
module tb_apb_master_arb;

   localparam int ADDR_W  = 2;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              p_clk = 1'b0;
   logic              p_reset_n;
   logic              req0_valid, req0_write, req1_valid, req1_write;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic [DATA_W-1:0] req0_wdata, req1_wdata;
   logic [1:0]        gnt, done;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err, busy, p_sel, p_enable, p_write;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_w_data;
   logic              p_ready, p_slv_err;
   logic [DATA_W-1:0] p_r_data;

   apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .p_clk(p_clk), .p_reset_n(p_reset_n),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_addr(p_addr), .p_w_data(p_w_data),
      .p_ready(p_ready), .p_slv_err(p_slv_err), .p_r_data(p_r_data)
   );

   always #5 p_clk = ~p_clk;

   typedef struct {
      logic [1:0]  g;
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
   } cmd_t;

   typedef struct {
      logic [1:0]  dn;
      logic [31:0] rd;
      logic        er;
      int          len;
   } rsp_t;

   cmd_t exp_gnt[$];
   rsp_t exp_done[$];

   int n_cmp = 0;
   int n_err = 0;

   int          s_wait  = 0;
   logic [31:0] s_rdata = '0;
   logic        s_err   = 1'b0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void push_cmd(int r, logic w, logic [1:0] a, logic [31:0] d);
      cmd_t c;
      c.g = (r == 1) ? 2'b10 : 2'b01;
      c.w = w;
      c.a = a;
      c.d = d;
      exp_gnt.push_back(c);
   endfunction

   function automatic void push_rsp(int r, logic [31:0] rd, logic er, int len);
      rsp_t e;
      e.dn  = (r == 1) ? 2'b10 : 2'b01;
      e.rd  = rd;
      e.er  = er;
      e.len = len;
      exp_done.push_back(e);
   endfunction

   // Simple APB slave: ready after s_wait not-ready ACCESS cycles.
   initial begin : slave
      int acc;
      acc       = 0;
      p_ready   = 1'b0;
      p_slv_err = 1'b0;
      p_r_data  = '0;
      forever begin
         @(negedge p_clk);
         if (p_sel && p_enable) begin
            p_ready = (acc >= s_wait);
            acc++;
         end else begin
            p_ready = 1'b0;
            acc     = 0;
         end
         p_slv_err = s_err;
         p_r_data  = s_rdata;
      end
   end

   // Monitor / scoreboard.
   initial begin : monitor
      cmd_t cur;
      rsp_t er;
      int   acc_len;
      acc_len = 0;
      cur.g = '0; cur.w = 1'b0; cur.a = '0; cur.d = '0;
      forever begin
         @(posedge p_clk);
         #1;
         if (!p_reset_n) begin
            acc_len = 0;
         end else begin
            if (gnt != 2'b00) begin
               if (exp_gnt.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'd0);
               else begin
                  cur = exp_gnt.pop_front();
                  chk("gnt", 64'(gnt), 64'(cur.g));
                  chk("setup_phase", 64'({p_sel, p_enable, busy}), 64'(3'b101));
                  chk("setup_cmd", 64'({p_write, p_addr, p_w_data}), 64'({cur.w, cur.a, cur.d}));
               end
            end
            if (p_sel && p_enable) begin
               acc_len++;
               chk("access_cmd", 64'({p_write, p_addr, p_w_data, busy}), 64'({cur.w, cur.a, cur.d, 1'b1}));
            end
            if (done != 2'b00) begin
               if (exp_done.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
               else begin
                  er = exp_done.pop_front();
                  chk("done", 64'(done), 64'(er.dn));
                  chk("rsp_rdata", 64'(rsp_rdata), 64'(er.rd));
                  chk("rsp_err", 64'(rsp_err), 64'(er.er));
                  chk("access_len", 64'(acc_len), 64'(er.len));
                  chk("psel_gap", 64'({p_sel, p_enable, busy}), 64'd0);
               end
               acc_len = 0;
            end
         end
      end
   end

   task automatic set_req(input int r, input logic v, input logic w, input logic [1:0] a, input logic [31:0] d);
      if (r == 0) begin
         req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
      end
   endtask

   task automatic wait_gnt(input int r);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge p_clk);
         #1;
         if (gnt[r]) ok = 1'b1;
      end
      if (!ok) chk("gnt_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge p_clk);
         #1;
         if (done != 2'b00) ok = 1'b1;
      end
      if (!ok) chk("done_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_ctl"}, 64'({gnt, done, rsp_err, busy, p_sel, p_enable, p_write, p_addr}), 64'd0);
      chk({nm, "_data"}, {rsp_rdata, p_w_data}, 64'd0);
   endtask

   // Single transfer from one requester; called at a negedge, returns at a negedge.
   task automatic xfer(input int r, input logic wr, input logic [1:0] a, input logic [31:0] wd,
                       input int wt, input logic [31:0] rd, input logic se);
      bit to;
      s_wait  = wt;
      s_rdata = rd;
      s_err   = se;
      to = (wt >= TIMEOUT);
      push_cmd(r, wr, a, wd);
      push_rsp(r, (to || wr) ? 32'd0 : rd, to ? 1'b1 : se, to ? TIMEOUT : wt + 1);
      set_req(r, 1'b1, wr, a, wd);
      wait_gnt(r);
      @(negedge p_clk);
      set_req(r, 1'b0, 1'b0, 2'd0, 32'd0);
      wait_done();
      @(negedge p_clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin : stim
      time tp, tn;
      p_reset_n = 1'b0;
      set_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 2'd0, 32'd0);
      repeat (3) @(posedge p_clk);
      #1;
      check_zero("reset");
      @(negedge p_clk);
      p_reset_n = 1'b1;
      @(negedge p_clk);

      // Write, zero wait states.
      xfer(0, 1'b1, 2'd1, 32'h0000_00A5, 0, 32'h5555_5555, 1'b0);
      // Read with 3 wait states.
      xfer(1, 1'b0, 2'd2, 32'h0, 3, 32'h1234_5678, 1'b0);

      // Both requesters held valid: round robin with a 3-cycle period.
      s_wait = 0; s_err = 1'b0; s_rdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         push_cmd(i % 2, 1'b1, 2'd3, (i % 2) ? 32'h22 : 32'h11);
         push_rsp(i % 2, 32'd0, 1'b0, 1);
      end
      set_req(0, 1'b1, 1'b1, 2'd3, 32'h11);
      set_req(1, 1'b1, 1'b1, 2'd3, 32'h22);
      tp = 0;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(i % 2);
         tn = $time;
         if (i > 0) chk("rr_period", 64'((tn - tp) / 10), 64'd3);
         tp = tn;
      end
      @(negedge p_clk);
      set_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 2'd0, 32'd0);
      wait_done();
      @(negedge p_clk);

      // Slave error on write, then clean read.
      xfer(0, 1'b1, 2'd0, 32'hFEED_0001, 0, 32'h0, 1'b1);
      xfer(1, 1'b0, 2'd2, 32'h0, 1, 32'hA5A5_0F0F, 1'b0);

      // Watchdog expiry, then a normal transfer.
      xfer(0, 1'b0, 2'd3, 32'h0, 1000, 32'hDEAD_BEEF, 1'b0);
      xfer(0, 1'b0, 2'd1, 32'h0, 2, 32'h0BAD_CAFE, 1'b0);

      // Reset during ACCESS: bus drops, no done.
      s_wait = 1000; s_err = 1'b0; s_rdata = 32'h1111_2222;
      push_cmd(0, 1'b0, 2'd1, 32'h0);
      set_req(0, 1'b1, 1'b0, 2'd1, 32'h0);
      wait_gnt(0);
      @(negedge p_clk);
      set_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
      @(negedge p_clk);
      chk("pre_reset_access", 64'({p_sel, p_enable}), 64'(2'b11));
      p_reset_n = 1'b0;
      @(posedge p_clk);
      #1;
      check_zero("mid_reset");
      @(negedge p_clk);
      p_reset_n = 1'b1;
      repeat (3) @(negedge p_clk);

      // After reset: req1 alone, then both -> req0 first.
      xfer(1, 1'b0, 2'd3, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
      s_wait = 0; s_err = 1'b0; s_rdata = 32'h7777_0000;
      push_cmd(0, 1'b1, 2'd2, 32'h0000_0AAA);
      push_rsp(0, 32'd0, 1'b0, 1);
      push_cmd(1, 1'b0, 2'd1, 32'h0000_0BBB);
      push_rsp(1, 32'h7777_0000, 1'b0, 1);
      set_req(0, 1'b1, 1'b1, 2'd2, 32'h0000_0AAA);
      set_req(1, 1'b1, 1'b0, 2'd1, 32'h0000_0BBB);
      wait_gnt(0);
      @(negedge p_clk);
      set_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
      wait_gnt(1);
      @(negedge p_clk);
      set_req(1, 1'b0, 1'b0, 2'd0, 32'd0);
      wait_done();
      repeat (5) @(negedge p_clk);

      chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
      chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
Two-port APB master that shares one APB slave port between two local requesters.
- Arbitrates round-robin between requesters and latches the winning command.
- Sequences the APB SETUP/ACCESS phases, honouring p_ready wait states.
- Returns read data and slave error to the winner; a watchdog aborts hung transfers.
- Sits between the block-level requesters and the memory-mapped APB slave register file.

Parameters:
ADDR_W, 2, APB address width (matches the 4-entry slave map)
DATA_W, 32, APB data width
TIMEOUT, 16, maximum ACCESS-phase cycles waiting on p_ready before abort (>=1)

Ports:
p_clk  in  1  clock
p_reset_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has a command
req0_write  in  1  requester 0: 1=write, 0=read
req0_addr  in  ADDR_W  requester 0 address
req0_wdata  in  DATA_W  requester 0 write data
req1_valid, req1_write, req1_addr, req1_wdata  in  1/1/ADDR_W/DATA_W  same, requester 1
gnt  out  2  one-hot accept pulse; command latched this cycle
done  out  2  one-hot completion pulse
rsp_rdata  out  DATA_W  read data, valid with done
rsp_err  out  1  slave error or timeout, valid with done
busy  out  1  high when not IDLE
p_sel  out  1  APB select
p_enable  out  1  APB enable
p_write  out  1  APB direction
p_addr  out  ADDR_W  APB address
p_w_data  out  DATA_W  APB write data
p_ready  in  1  slave ready
p_slv_err  in  1  slave error
p_r_data  in  DATA_W  slave read data

Behaviour:
- Reset (p_reset_n=0 at a p_clk edge): all outputs 0, state=IDLE, timeout count=0, last_grant=1 (requester 0 wins first). Takes effect at that edge mid-transfer too: no done is issued, bus drops immediately, and the latched command is discarded.
- FSM states:
  - IDLE: if any reqN_valid is high, go to SETUP.
  - SETUP: always go to ACCESS after one cycle.
  - ACCESS: on p_ready=1 or timeout, go to IDLE; otherwise stay.
- Arbitration happens only in IDLE.
  - One valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins; last_grant is then updated.
- Accept: at the edge leaving IDLE, the winner's write/addr/wdata are registered onto p_write/p_addr/p_w_data. gnt[winner]=1 for exactly the SETUP cycle.
  - After gnt, the requester may change or drop its inputs.
  - A valid still high after gnt is treated as a new command.
- SETUP cycle: p_sel=1, p_enable=0.
- ACCESS cycles: p_sel=1, p_enable=1. p_addr/p_write/p_w_data are held stable from SETUP through the end of ACCESS.
- Completion on the edge where ACCESS sees p_ready=1:
  - p_sel and p_enable go to 0.
  - done[winner]=1 for one cycle, during the following IDLE cycle.
  - rsp_err=p_slv_err.
  - rsp_rdata=p_r_data for reads, 0 for writes.
  - rsp_rdata/rsp_err hold until the next completion.
- Latency: valid seen in IDLE at edge k gives SETUP after edge k, ACCESS after edge k+1. Zero wait states give done after edge k+2. Each p_ready=0 ACCESS cycle adds 1.
- Back-to-back: the IDLE cycle carrying done also arbitrates. The minimum transfer period is 3 cycles, with p_sel low for 1 cycle between transfers.
- Timeout: the counter increments on each ACCESS cycle with p_ready=0 and clears in SETUP. When the count reaches TIMEOUT, the transfer completes as above with rsp_err=1 and rsp_rdata=0, and p_slv_err is ignored.
- p_ready and p_slv_err are ignored outside ACCESS.
- p_w_data is don't-care for reads but driven with the latched value.
- busy=1 in SETUP and ACCESS.

Test Plan:
1. req0 write addr=1 wdata=0x000000A5, p_ready=1 in ACCESS -> gnt=01 after edge 1; SETUP p_sel=1/p_enable=0; ACCESS p_enable=1 with p_addr=1, p_w_data=0xA5; done=01 after edge 3; rsp_err=0.
2. req1 read addr=2, slave returns p_r_data=0x12345678 with p_ready low for 3 ACCESS cycles -> ACCESS lasts 4 cycles with address stable; done=10; rsp_rdata=0x12345678.
3. req0 and req1 both held valid continuously after reset -> grants 01,10,01,10 with a 3-cycle period; exactly one done per gnt, to the same requester.
4. Write to addr=0 with p_slv_err=1 at p_ready -> done pulse, rsp_err=1; a following read of addr=2 with p_slv_err=0 -> rsp_err=0.
5. TIMEOUT=16, p_ready held 0 -> done after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; p_sel=0 the next cycle; a new request is then served normally.
6. Assert p_reset_n=0 for one edge during ACCESS -> all outputs 0 at that edge, no done; after release, req1 alone is granted first, and with both valid, req0 is granted first.
